// File: rtl/isp_pix_pkg.sv
// rtl/isp_pix_pkg.sv - shared pixel/beat widths, pixel struct and beat assembly helper
package isp_pix_pkg;

  localparam int PIX_W        = 24;
  localparam int PIX_PER_BEAT = 4;
  localparam int BEAT_W       = PIX_W * PIX_PER_BEAT;
  localparam int SLOT_W       = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  // Slots below idx keep base, slot idx takes pix, slots above idx take pad.
  function automatic logic [BEAT_W-1:0] build_beat(
    input logic [BEAT_W-1:0] base,
    input logic [SLOT_W-1:0] idx,
    input logic [PIX_W-1:0]  pix,
    input logic [PIX_W-1:0]  pad
  );
    logic [BEAT_W-1:0] r;
    r = base;
    for (int s = 0; s < PIX_PER_BEAT; s++) begin
      if (s == int'(idx)) begin
        r[s*PIX_W +: PIX_W] = pix;
      end else if (s > int'(idx)) begin
        r[s*PIX_W +: PIX_W] = pad;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/isp_beat_reg.sv
// rtl/isp_beat_reg.sv - output beat holding register with valid/ready handshake
module isp_beat_reg
  import isp_pix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BEAT_W-1:0] load_data,
  input  logic              load_user,
  input  logic              load_last,
  output logic              free,
  output logic [BEAT_W-1:0] tdata,
  output logic              tvalid,
  input  logic              tready,
  output logic              tuser,
  output logic              tlast
);

  // A new beat may enter when the register is empty or drains this cycle.
  assign free = !tvalid || tready;

  // Load on request (callers only load when free); otherwise drop valid once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tuser  <= 1'b0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= load_data;
      tuser  <= load_user;
      tlast  <= load_last;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/rgb888_pix_packer.sv
// rtl/rgb888_pix_packer.sv - packs 1-pixel/clk RGB888 stream into 4-pixel 96-bit beats
module rgb888_pix_packer
  import isp_pix_pkg::*;
#(
  parameter bit PAD_REPEAT = 1'b0
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic [PIX_W-1:0]  I_tdata,
  input  logic              I_tvalid,
  output logic              I_tready,
  input  logic              I_tuser,
  input  logic              I_tlast,
  output logic [BEAT_W-1:0] O_tdata,
  output logic              O_tvalid,
  input  logic              O_tready,
  output logic              O_tuser,
  output logic              O_tlast,
  output logic              O_sof_err
);

  logic [SLOT_W-1:0] cnt;
  logic [BEAT_W-1:0] acc_data;
  logic              acc_user;
  logic              pend;
  logic              pend_last;
  logic              sof_err_q;

  pix_t              in_pix;
  logic              accept;
  logic              restart;
  logic [SLOT_W-1:0] slot;
  logic              complete;
  logic              beat_user;
  logic [PIX_W-1:0]  pad_pix;
  logic [BEAT_W-1:0] new_beat;

  logic              free;
  logic              load;
  logic [BEAT_W-1:0] load_data;
  logic              load_user;
  logic              load_last;

  assign in_pix   = pix_t'(I_tdata);
  assign I_tready = !pend;
  assign accept   = I_tvalid && !pend;

  // Start-of-frame mid-beat abandons the partial beat and restarts at slot 0.
  assign restart  = I_tuser && (cnt != '0);
  assign slot     = I_tuser ? '0 : cnt;
  assign complete = accept && ((slot == SLOT_W'(PIX_PER_BEAT - 1)) || I_tlast);

  // Beat-level tuser is the tuser captured with the pixel in slot 0.
  assign beat_user = (slot == '0) ? I_tuser : acc_user;
  assign pad_pix   = PAD_REPEAT ? in_pix : '0;
  assign new_beat  = build_beat(acc_data, slot, in_pix, pad_pix);

  // A parked beat has priority; no pixel can arrive while one is parked.
  always_comb begin
    load      = 1'b0;
    load_data = new_beat;
    load_user = beat_user;
    load_last = I_tlast;
    if (pend) begin
      load      = free;
      load_data = acc_data;
      load_user = acc_user;
      load_last = pend_last;
    end else if (complete) begin
      load = free;
    end
  end

  // Accumulator: slot counter, partial beat data, parked-beat flag and sof error pulse.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      cnt       <= '0;
      acc_data  <= '0;
      acc_user  <= 1'b0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      sof_err_q <= 1'b0;
    end else begin
      sof_err_q <= accept && restart;
      if (pend) begin
        if (free) begin
          pend <= 1'b0;
        end
      end else if (accept) begin
        acc_data <= new_beat;
        acc_user <= beat_user;
        if (complete) begin
          cnt <= '0;
          if (!free) begin
            pend      <= 1'b1;
            pend_last <= I_tlast;
          end
        end else begin
          cnt <= slot + SLOT_W'(1);
        end
      end
    end
  end

  assign O_sof_err = sof_err_q;

  isp_beat_reg u_beat_reg (
    .clk       (I_clk),
    .rst       (I_rst),
    .load      (load),
    .load_data (load_data),
    .load_user (load_user),
    .load_last (load_last),
    .free      (free),
    .tdata     (O_tdata),
    .tvalid    (O_tvalid),
    .tready    (O_tready),
    .tuser     (O_tuser),
    .tlast     (O_tlast)
  );

endmodule

// File: tb/tb_rgb888_pix_packer.sv
// tb/tb_rgb888_pix_packer.sv - scoreboard bench for both padding variants of the packer
module tb_rgb888_pix_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] tdata;
  logic        tuser;
  logic        tlast;
  logic [1:0]  v;
  logic        o_rdy;
  logic [1:0]  rdy;
  logic [1:0]  ov;
  logic [1:0]  ou;
  logic [1:0]  ol;
  logic [1:0]  se;
  logic [95:0] od [2];

  int checks = 0;
  int errors = 0;
  int bp_mode = 0;

  logic [97:0] expq [2][$];
  logic [23:0] pq [2][$];
  logic        puser [2];
  logic        sof_exp [2];
  int          acc_total [2];
  int          beats_out [2];
  logic        hold_v [2];
  logic [98:0] hold_val [2];

  always #5 clk = ~clk;

  rgb888_pix_packer #(.PAD_REPEAT(1'b0)) u0 (
    .I_clk(clk), .I_rst(rst), .I_tdata(tdata), .I_tvalid(v[0]), .I_tready(rdy[0]),
    .I_tuser(tuser), .I_tlast(tlast), .O_tdata(od[0]), .O_tvalid(ov[0]), .O_tready(o_rdy),
    .O_tuser(ou[0]), .O_tlast(ol[0]), .O_sof_err(se[0])
  );

  rgb888_pix_packer #(.PAD_REPEAT(1'b1)) u1 (
    .I_clk(clk), .I_rst(rst), .I_tdata(tdata), .I_tvalid(v[1]), .I_tready(rdy[1]),
    .I_tuser(tuser), .I_tlast(tlast), .O_tdata(od[1]), .O_tvalid(ov[1]), .O_tready(o_rdy),
    .O_tuser(ou[1]), .O_tlast(ol[1]), .O_sof_err(se[1])
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: gather pixels into a list, emit a padded beat at 4 pixels or end of line.
  task automatic model_accept(input int k, input logic [23:0] p, input logic u, input logic l);
    logic [95:0] b;
    if (u && pq[k].size() != 0) begin
      sof_exp[k] = 1'b1;
      pq[k].delete();
    end
    if (pq[k].size() == 0) puser[k] = u;
    pq[k].push_back(p);
    if (pq[k].size() == 4 || l) begin
      b = '0;
      for (int s = 0; s < 4; s++) begin
        if (s < pq[k].size()) b[s*24 +: 24] = pq[k][s];
        else b[s*24 +: 24] = (k == 1) ? p : 24'h0;
      end
      expq[k].push_back({puser[k], l, b});
      pq[k].delete();
    end
  endtask

  // Input observer: checks sof_err timing and feeds accepted pixels to the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pq[k].delete();
        expq[k].delete();
        sof_exp[k] = 1'b0;
      end else begin
        chk($sformatf("sof_err%0d", k), se[k], sof_exp[k]);
        sof_exp[k] = 1'b0;
        if (v[k] && rdy[k]) begin
          acc_total[k]++;
          model_accept(k, tdata, tuser, tlast);
        end
      end
    end
  end

  // Output monitor: pops expected beats on each transfer and checks stall stability.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        hold_v[k] = 1'b0;
      end else begin
        if (hold_v[k]) chk($sformatf("stall_hold%0d", k), {ov[k], ou[k], ol[k], od[k]}, hold_val[k]);
        if (ov[k] && o_rdy) begin
          beats_out[k]++;
          if (expq[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat%0d actual=%0h required=none", k, od[k]);
          end else begin
            chk($sformatf("beat%0d", k), {ou[k], ol[k], od[k]}, expq[k].pop_front());
          end
        end
        hold_v[k] = ov[k] && !o_rdy;
        hold_val[k] = {ov[k], ou[k], ol[k], od[k]};
      end
    end
  end

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      1: o_rdy = ($urandom % 3) != 0;
      2: o_rdy = 1'b0;
      default: o_rdy = 1'b1;
    endcase
  end

  task automatic send(input logic [23:0] p, input logic u, input logic l);
    logic [1:0] a;
    int n = 0;
    tdata = p;
    tuser = u;
    tlast = l;
    v = 2'b11;
    while (v != 2'b00 && n < 200) begin
      @(negedge clk);
      a = v & rdy;
      @(posedge clk);
      #1;
      v = v & ~a;
      n++;
    end
    if (v != 2'b00) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=%0b required=0", v);
      v = 2'b00;
    end
    tuser = 1'b0;
    tlast = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq[0].size() != 0 || expq[1].size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", {expq[0].size(), expq[1].size()}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base0;
    int base1;
    rst = 1'b1;
    v = 2'b00;
    tdata = '0;
    tuser = 1'b0;
    tlast = 1'b0;
    o_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      acc_total[k] = 0;
      beats_out[k] = 0;
      hold_v[k] = 1'b0;
      puser[k] = 1'b0;
      sof_exp[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", ov, 2'b00);
    chk("rst_tuser", ou, 2'b00);
    chk("rst_tlast", ol, 2'b00);
    chk("rst_sof_err", se, 2'b00);
    chk("rst_tdata", {od[0], od[1]}, 0);
    chk("rst_tready", rdy, 2'b11);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 1; i <= 8; i++) begin
      send(24'(i), 1'b0, 1'b0);
      chk("aligned_tready", rdy, 2'b11);
      if (i == 4) chk("latency_tvalid", ov, 2'b11);
    end
    drain();

    for (int i = 0; i < 6; i++) send(24'h10 + 24'(i), 1'b0, i == 5);
    drain();

    bp_mode = 2;
    @(posedge clk);
    #2;
    base0 = acc_total[0];
    base1 = acc_total[1];
    fork
      begin
        for (int i = 0; i < 12; i++) send(24'hA00000 + 24'(i), 1'b0, 1'b0);
      end
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepted", {acc_total[0] - base0, acc_total[1] - base1}, {32'd8, 32'd8});
        chk("bp_tready", rdy, 2'b00);
        bp_mode = 0;
      end
    join
    drain();

    send(24'h100, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) send(24'h100 + 24'(i), 1'b0, 1'b0);
    send(24'h200, 1'b0, 1'b0);
    send(24'h201, 1'b0, 1'b0);
    send(24'h202, 1'b1, 1'b0);
    for (int i = 3; i < 6; i++) send(24'h200 + 24'(i), 1'b0, 1'b0);
    send(24'h300, 1'b1, 1'b1);
    drain();

    bp_mode = 1;
    for (int i = 0; i < 400; i++) begin
      send(24'($urandom), ($urandom % 20) == 0, ($urandom % 8) == 0);
      if (($urandom % 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    send(24'($urandom), 1'b0, 1'b1);
    drain();
    bp_mode = 0;

    send(24'h400, 1'b0, 1'b0);
    send(24'h401, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tvalid", ov, 2'b00);
    chk("arst_tuser", ou, 2'b00);
    chk("arst_tlast", ol, 2'b00);
    chk("arst_tdata", {od[0], od[1]}, 0);
    chk("arst_tready", rdy, 2'b11);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base0 = beats_out[0];
    base1 = beats_out[1];
    for (int i = 0; i < 4; i++) send(24'h500 + 24'(i), 1'b0, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_one_beat", {beats_out[0] - base0, beats_out[1] - base1}, {32'd1, 32'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb888_pix_packer.md
# rgb888_pix_packer

Packs a 1-pixel-per-clock RGB888 AXI-Stream video input into 4-pixel, 96-bit beats for the ISP pixel chain. It sits directly upstream of the 4-pixel brightness stage and drives its slave port. It preserves frame and line markers, pads short line tails, and sustains full throughput under output backpressure.

## Interface
Parameters:
- PAD_REPEAT, 0, tail padding for incomplete beats: 0 = zero pixels, 1 = repeat the last accepted pixel.

Ports:
- I_clk  input  1  single clock for the whole block.
- I_rst  input  1  asynchronous, active-high reset.
- I_tdata  input  24  pixel, {R[23:16], G[15:8], B[7:0]}.
- I_tvalid  input  1  input pixel valid.
- I_tready  output  1  input ready.
- I_tuser  input  1  start of frame; marks the first pixel of a frame.
- I_tlast  input  1  end of line; marks the last pixel of a line.
- O_tdata  output  96  4 pixels; pixel k (arrival order 0..3) occupies [24k+23:24k].
- O_tvalid  output  1  output beat valid.
- O_tready  input  1  downstream ready.
- O_tuser  output  1  beat holds the frame's first pixel in slot 0.
- O_tlast  output  1  beat holds the line's last pixel.
- O_sof_err  output  1  one-cycle pulse: a partial beat was discarded because I_tuser arrived mid-beat.

## Operation
- A pixel is accepted on I_tvalid && I_tready. The accumulator holds slot count cnt[1:0], the data, and the captured tuser of slot 0.
- Each accepted pixel is written to slot cnt, and cnt increments.
- A beat completes on:
  - acceptance into slot 3, or
  - acceptance of a pixel with I_tlast in any slot. Empty slots above it are padded per PAD_REPEAT, O_tlast is set for that beat, and cnt returns to 0.
- Completed-beat handling:
  - If the output register is empty, or is being consumed this cycle (O_tvalid && O_tready), the beat loads the output register directly.
  - Otherwise it stays in the accumulator with `pend` = 1. While pend = 1, I_tready = 0.
- A pending beat moves to the output register on the cycle the output is consumed. Pend clears and I_tready returns to 1 in the next cycle.
- I_tready = !pend. The register is not combinationally dependent on I_tvalid.
- I_tuser on a pixel accepted at cnt ≠ 0:
  - The partial beat is discarded and O_sof_err pulses for 1 cycle.
  - That pixel goes to slot 0 with tuser = 1.
- I_tuser and I_tlast on the same pixel at slot 0 (1-pixel line): one beat with O_tuser = O_tlast = 1, slots 1..3 padded.
- Output beats are never modified while O_tvalid = 1 and O_tready = 0.

## Timing
- Reset values: O_tvalid = 0, O_tdata = 0, O_tuser = 0, O_tlast = 0, O_sof_err = 0. I_tready = 1 after reset (pend = 0), cnt = 0.
- Reset mid-line discards the accumulator and output register, with no flush.
- Latency: the completing pixel is accepted in cycle N, and O_tvalid is asserted from cycle N+1.
- Throughput: 1 pixel/clk sustained while O_tready = 1. O_tready low for k cycles stalls the input at most k cycles after the accumulator fills.
- O_sof_err asserts in the cycle after the offending acceptance.

## Structure
- Shared package `isp_pix_pkg`:
  - PIX_W = 24, PIX_PER_BEAT = 4, BEAT_W = 96.
  - Slot-index width.
  - Pixel struct {r, g, b}.
- One natural sub-module, `isp_beat_reg`: the output holding register. It owns the valid/ready handshake and load-on-empty-or-consume, and presents a `free` signal to the accumulator.

## Test plan
- **Aligned packing:** feed 0x000001..0x000008 continuously with O_tready = 1.
  - Expect 2 beats: 96'h000004_000003_000002_000001, then 96'h000008_000007_000006_000005.
  - O_tvalid at acceptance+1; I_tready stays 1.
- **Short line, PAD_REPEAT = 0:** 6 pixels 0x10..0x15, last with I_tlast.
  - Second beat = {0, 0, 0x15, 0x14} with O_tlast = 1; first beat O_tlast = 0.
- **Short line, PAD_REPEAT = 1:** same stimulus.
  - Second beat = {0x15, 0x15, 0x15, 0x14}.
- **Backpressure:** hold O_tready = 0 for 10 cycles while feeding 12 pixels continuously.
  - I_tready drops 0 once 8 pixels are accepted.
  - No beat is lost or reordered; after release, beats appear in order with data intact while stalled.
- **Frame markers:**
  - I_tuser on pixel 0: beat 0 has O_tuser = 1.
  - I_tuser on the 3rd pixel of a group: O_sof_err pulses once, the earlier 2 pixels are absent from the output, and the next beat starts with the tuser pixel (O_tuser = 1).
  - A 1-pixel line with tuser + tlast gives a beat with O_tuser = O_tlast = 1.
- **Reset:** assert I_rst after 2 pixels of a beat.
  - All outputs go to 0 asynchronously.
  - After release, 4 new pixels produce exactly one beat containing only those pixels.
